// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the 64-bit push side of a single FIFO among
// N_REQ producer engines. A granted producer owns the FIFO for one burst.
// The burst ends on the producer's last flag or after MAX_BURST words,
// whichever comes first. The grant then rotates to the next requester.
// Every burst costs one arbitration cycle in IDLE before it starts.
//
// Optional build macro:
//   ARB_WATCHDOG_EN - adds a stall watchdog. A burst whose owner stops
//                     presenting valid (while the FIFO has room) for
//                     WD_CYCLES cycles is force-terminated, and wd_err pulses
//                     for one cycle. Without the macro, the grant is held
//                     indefinitely and wd_err is tied low.
//
// Parameters:
//   N_REQ     - number of requesters (2..8; 1 degenerates to IDLE/BURST toggle)
//   DATA_W    - word width, matches FIFO push width
//   MAX_BURST - maximum words per grant (1..255)
//   WD_CYCLES - watchdog stall limit in cycles (watchdog build only)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]        per-requester word valid
//   req_last   in   [N_REQ]        per-requester last word, qualified by valid
//   req_data   in   [N_REQ*DATA_W] packed words, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [N_REQ]        per-requester accept, one-hot or zero
//   fifo_push  out                 push strobe to FIFO
//   fifo_d     out  [DATA_W]       data to FIFO
//   fifo_full  in                  FIFO full flag
//   grant_id   out  [3]            current or most recent granted requester
//   busy       out                 high while a burst is in progress
//   wd_err     out                 one-cycle pulse on watchdog release
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 8,
   parameter int WD_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      fifo_push,
   output logic [DATA_W-1:0]         fifo_d,
   input  logic                      fifo_full,
   output logic [2:0]                grant_id,
   output logic                      busy,
   output logic                      wd_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  grant_reg, grant_next;
   logic [2:0]  rr_ptr_reg, rr_ptr_next;
   logic [7:0]  beat_cnt_reg, beat_cnt_next;
   logic        wd_err_reg, wd_err_next;

   // ---------------------------------------------------------------------------
   // Granted-requester selection. A one-hot decode of grant_reg keeps every
   // index in range even when N_REQ is not a power of two.
   // ---------------------------------------------------------------------------
   logic [N_REQ-1:0]  grant_onehot;
   logic [DATA_W-1:0] masked_word [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
         assign grant_onehot[gi] = (grant_reg == 3'(gi));
         assign masked_word[gi]  = grant_onehot[gi] ? req_data[gi*DATA_W +: DATA_W]
                                                    : '0;
      end
   endgenerate

   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;

   assign sel_valid = |(req_valid & grant_onehot);
   assign sel_last  = |(req_last & grant_onehot);

   // AND-OR mux: at most one masked word is non-zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_data = sel_data | masked_word[i];
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin pick: first valid requester scanning from rr_ptr upwards,
   // wrapping modulo N_REQ. rr_ptr is always < N_REQ, so a single
   // conditional subtract performs the wrap.
   // ---------------------------------------------------------------------------
   logic       pick_found;
   logic [2:0] pick_idx;
   int         scan_idx;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = int'(rr_ptr_reg) + k;
         if (scan_idx >= N_REQ) begin
            scan_idx = scan_idx - N_REQ;
         end
         if (!pick_found && req_valid[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = 3'(scan_idx);
         end
      end
   end

   // Pointer for the requester after the current grant, modulo N_REQ.
   logic [2:0] next_ptr;
   assign next_ptr = (int'(grant_reg) + 1 >= N_REQ) ? 3'd0 : grant_reg + 3'd1;

   // ---------------------------------------------------------------------------
   // Transfer and burst termination
   // ---------------------------------------------------------------------------
   logic in_burst;
   logic xfer;
   logic last_beat;
   logic burst_end;
   logic wd_fire;

   assign in_burst  = (state_reg == BURST);
   assign xfer      = in_burst & sel_valid & ~fifo_full;
   // beat_cnt counts completed transfers, so the transfer made while it equals
   // MAX_BURST-1 is word number MAX_BURST.
   assign last_beat = (beat_cnt_reg == 8'(MAX_BURST - 1));
   assign burst_end = xfer & (sel_last | last_beat);

`ifdef ARB_WATCHDOG_EN
   // Stall counter: counts burst cycles where the owner has nothing to offer
   // although the FIFO could accept. Back-pressure stalls are not the
   // producer's fault and never count.
   logic [15:0] stall_cnt_reg;
   logic        stall;

   assign stall   = in_burst & ~sel_valid & ~fifo_full;
   assign wd_fire = stall & (stall_cnt_reg == 16'(WD_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (!in_burst || xfer || wd_fire) begin
         stall_cnt_reg <= '0;
      end else if (stall) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end
`else
   logic unused_wd_cfg;

   assign wd_fire       = 1'b0;
   assign unused_wd_cfg = ^WD_CYCLES;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         rr_ptr_reg   <= '0;
         beat_cnt_reg <= '0;
         wd_err_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         beat_cnt_reg <= beat_cnt_next;
         wd_err_reg   <= wd_err_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      beat_cnt_next = beat_cnt_reg;
      wd_err_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               grant_next    = pick_idx;
               beat_cnt_next = '0;
               state_next    = BURST;
            end
         end
         BURST: begin
            if (xfer) begin
               beat_cnt_next = beat_cnt_reg + 8'd1;
            end
            if (burst_end || wd_fire) begin
               rr_ptr_next = next_ptr;
               state_next  = IDLE;
            end
            wd_err_next = wd_fire;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs. The datapath is combinational from the grant so a word moves in
   // the same cycle it is offered.
   // ---------------------------------------------------------------------------
   assign busy      = in_burst;
   assign req_ready = (in_burst && !fifo_full) ? grant_onehot : '0;
   assign fifo_push = xfer;
   assign fifo_d    = in_burst ? sel_data : '0;
   assign grant_id  = grant_reg;
   assign wd_err    = wd_err_reg;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed self-checking bench for fifo_write_arbiter with N_REQ=4,
// DATA_W=64, MAX_BURST=8, WD_CYCLES=16. Inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 64;
   localparam int MAX_BURST = 8;
   localparam int WD_CYCLES = 16;

   logic                    clk;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    fifo_push;
   logic [DATA_W-1:0]       fifo_d;
   logic                    fifo_full;
   logic [2:0]              grant_id;
   logic                    busy;
   logic                    wd_err;

   int errors = 0;
   int checks = 0;

   fifo_write_arbiter #(
      .N_REQ     (N_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST),
      .WD_CYCLES (WD_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_push (fifo_push),
      .fifo_d    (fifo_d),
      .fifo_full (fifo_full),
      .grant_id  (grant_id),
      .busy      (busy),
      .wd_err    (wd_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_word(input int idx, input logic [63:0] w);
      req_data[idx*DATA_W +: DATA_W] = w;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Reset state, then 10 idle cycles with no requests.
   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy, fifo_push, req_ready, grant_id, wd_err} !== 10'b0 || fifo_d !== 64'd0) begin
         errors++;
         $display("FAIL reset_hold: busy=%b push=%b ready=%b grant=%0d wd_err=%b d=%h, required all 0",
                  busy, fifo_push, req_ready, grant_id, wd_err, fifo_d);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if ({busy, fifo_push, req_ready, grant_id, wd_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: busy=%b push=%b ready=%b grant=%0d wd_err=%b, required all 0",
                     c, busy, fifo_push, req_ready, grant_id, wd_err);
         end
      end
      $display("test_reset done");
   endtask

   // Requester 2 alone, three words with last on the third.
   task automatic test_single();
      req_valid = 4'b0100;
      set_word(2, 64'hA1);
      settle();
      checks++;
      if ({busy, fifo_push} !== 2'b00) begin
         errors++;
         $display("FAIL single_arb_cycle: busy=%b push=%b, required 0 0", busy, fifo_push);
      end
      tick();
      for (int w = 1; w <= 3; w++) begin
         set_word(2, 64'hA0 + 64'(w));
         req_last[2] = (w == 3);
         settle();
         checks++;
         if ({busy, fifo_push, req_ready, grant_id} !== {1'b1, 1'b1, 4'b0100, 3'd2}
             || fifo_d !== 64'hA0 + 64'(w)) begin
            errors++;
            $display("FAIL single_word%0d: busy=%b push=%b ready=%b grant=%0d d=%h, required 1 1 0100 2 %h",
                     w, busy, fifo_push, req_ready, grant_id, fifo_d, 64'hA0 + 64'(w));
         end
         tick();
      end
      req_valid = '0;
      req_last  = '0;
      settle();
      checks++;
      if ({busy, fifo_push, req_ready, grant_id} !== {1'b0, 1'b0, 4'b0000, 3'd2}) begin
         errors++;
         $display("FAIL single_end: busy=%b push=%b ready=%b grant=%0d, required 0 0 0000 2",
                  busy, fifo_push, req_ready, grant_id);
      end
      $display("test_single done");
   endtask

   // rr_ptr=3 after the previous burst: requester 3 wins over 0, then 0 gets a
   // one-word burst because its first word carries last.
   task automatic test_rr_pointer();
      req_valid = 4'b1001;
      req_last  = 4'b0001;
      set_word(0, 64'hB0);
      set_word(3, 64'hC1);
      tick();
      settle();
      checks++;
      if ({busy, fifo_push, req_ready, grant_id} !== {1'b1, 1'b1, 4'b1000, 3'd3} || fifo_d !== 64'hC1) begin
         errors++;
         $display("FAIL rr_first_grant: busy=%b push=%b ready=%b grant=%0d d=%h, required 1 1 1000 3 c1",
                  busy, fifo_push, req_ready, grant_id, fifo_d);
      end
      tick();
      set_word(3, 64'hC2);
      req_last[3] = 1'b1;
      settle();
      checks++;
      if (grant_id !== 3'd3 || fifo_push !== 1'b1 || fifo_d !== 64'hC2) begin
         errors++;
         $display("FAIL rr_req3_word2: grant=%0d push=%b d=%h, required 3 1 c2", grant_id, fifo_push, fifo_d);
      end
      tick();
      req_valid[3] = 1'b0;
      req_last[3]  = 1'b0;
      settle();
      checks++;
      if ({busy, fifo_push} !== 2'b00) begin
         errors++;
         $display("FAIL rr_dead_cycle: busy=%b push=%b, required 0 0", busy, fifo_push);
      end
      tick();
      settle();
      checks++;
      if ({busy, fifo_push, req_ready, grant_id} !== {1'b1, 1'b1, 4'b0001, 3'd0} || fifo_d !== 64'hB0) begin
         errors++;
         $display("FAIL rr_second_grant: busy=%b push=%b ready=%b grant=%0d d=%h, required 1 1 0001 0 b0",
                  busy, fifo_push, req_ready, grant_id, fifo_d);
      end
      tick();
      req_valid = '0;
      req_last  = '0;
      settle();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_one_word_end: busy=%b, required 0", busy);
      end
      $display("test_rr_pointer done");
   endtask

   // All requesters always valid, never last: grants 0,1,2,3,0 of 8 words each.
   task automatic test_round_robin();
      int g;
      do_reset();
      req_valid = 4'hF;
      for (int n = 0; n < 5; n++) begin
         g = n % N_REQ;
         settle();
         checks++;
         if ({busy, fifo_push} !== 2'b00) begin
            errors++;
            $display("FAIL rr_gap grant%0d: busy=%b push=%b, required 0 0", n, busy, fifo_push);
         end
         tick();
         for (int b = 0; b < MAX_BURST; b++) begin
            for (int i = 0; i < N_REQ; i++) begin
               set_word(i, (64'(i) << 8) | 64'(b));
            end
            settle();
            checks++;
            if ({busy, fifo_push, req_ready, grant_id} !== {1'b1, 1'b1, 4'(1 << g), 3'(g)}
                || fifo_d !== ((64'(g) << 8) | 64'(b))) begin
               errors++;
               $display("FAIL rr_beat grant%0d beat%0d: busy=%b push=%b ready=%b grant=%0d d=%h, required 1 1 %b %0d %h",
                        n, b, busy, fifo_push, req_ready, grant_id, fifo_d, 4'(1 << g), g,
                        (64'(g) << 8) | 64'(b));
            end
            tick();
         end
      end
      req_valid = '0;
      $display("test_round_robin done");
   endtask

   // fifo_full for 5 cycles after word 2 of requester 1; 8 words in total.
   task automatic test_fifo_full();
      do_reset();
      req_valid = 4'b0010;
      tick();
      for (int w = 1; w <= 2; w++) begin
         set_word(1, 64'hD0 + 64'(w));
         settle();
         checks++;
         if (fifo_push !== 1'b1 || fifo_d !== 64'hD0 + 64'(w)) begin
            errors++;
            $display("FAIL full_pre word%0d: push=%b d=%h, required 1 %h", w, fifo_push, fifo_d, 64'hD0 + 64'(w));
         end
         tick();
      end
      fifo_full = 1'b1;
      set_word(1, 64'hD3);
      for (int s = 0; s < 5; s++) begin
         settle();
         checks++;
         if ({busy, fifo_push, req_ready, grant_id} !== {1'b1, 1'b0, 4'b0000, 3'd1}) begin
            errors++;
            $display("FAIL full_stall cycle%0d: busy=%b push=%b ready=%b grant=%0d, required 1 0 0000 1",
                     s, busy, fifo_push, req_ready, grant_id);
         end
         tick();
      end
      fifo_full = 1'b0;
      for (int w = 3; w <= 8; w++) begin
         set_word(1, 64'hD0 + 64'(w));
         settle();
         checks++;
         if ({busy, fifo_push, req_ready} !== {1'b1, 1'b1, 4'b0010} || fifo_d !== 64'hD0 + 64'(w)) begin
            errors++;
            $display("FAIL full_post word%0d: busy=%b push=%b ready=%b d=%h, required 1 1 0010 %h",
                     w, busy, fifo_push, req_ready, fifo_d, 64'hD0 + 64'(w));
         end
         tick();
      end
      req_valid = '0;
      settle();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL full_total: busy=%b after 8 words, required 0", busy);
      end
      $display("test_fifo_full done");
   endtask

   // Reset asserted in the middle of a burst takes effect without a clock edge.
   task automatic test_reset_mid_burst();
      do_reset();
      req_valid = 4'b0100;
      set_word(2, 64'hE1);
      tick();
      settle();
      checks++;
      if (fifo_push !== 1'b1 || grant_id !== 3'd2) begin
         errors++;
         $display("FAIL midrst_pre: push=%b grant=%0d, required 1 2", fifo_push, grant_id);
      end
      tick();
      rst_n = 1'b0;
      settle();
      checks++;
      if ({busy, fifo_push, req_ready, grant_id, wd_err} !== 10'b0 || fifo_d !== 64'd0) begin
         errors++;
         $display("FAIL midrst_async: busy=%b push=%b ready=%b grant=%0d wd_err=%b d=%h, required all 0",
                  busy, fifo_push, req_ready, grant_id, wd_err, fifo_d);
      end
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();
      $display("test_reset_mid_burst done");
   endtask

   // Owner of the grant stops offering words after two transfers while
   // requester 2 waits.
   task automatic test_stall();
      do_reset();
      req_valid = 4'b0010;
      tick();
      for (int w = 1; w <= 2; w++) begin
         set_word(1, 64'hF0 + 64'(w));
         settle();
         checks++;
         if (fifo_push !== 1'b1 || fifo_d !== 64'hF0 + 64'(w)) begin
            errors++;
            $display("FAIL stall_pre word%0d: push=%b d=%h, required 1 %h", w, fifo_push, fifo_d, 64'hF0 + 64'(w));
         end
         tick();
      end
      req_valid = 4'b0100;
`ifdef ARB_WATCHDOG_EN
      for (int s = 0; s < WD_CYCLES; s++) begin
         settle();
         checks++;
         if ({busy, grant_id, wd_err, fifo_push} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wd_wait cycle%0d: busy=%b grant=%0d wd_err=%b push=%b, required 1 1 0 0",
                     s, busy, grant_id, wd_err, fifo_push);
         end
         tick();
      end
      settle();
      checks++;
      if ({busy, wd_err} !== 2'b01) begin
         errors++;
         $display("FAIL wd_fire: busy=%b wd_err=%b, required 0 1", busy, wd_err);
      end
      tick();
      settle();
      checks++;
      if ({busy, wd_err, grant_id} !== {1'b1, 1'b0, 3'd2}) begin
         errors++;
         $display("FAIL wd_next_grant: busy=%b wd_err=%b grant=%0d, required 1 0 2", busy, wd_err, grant_id);
      end
`else
      for (int s = 0; s < 2 * WD_CYCLES; s++) begin
         settle();
         checks++;
         if ({busy, grant_id, wd_err, fifo_push, req_ready} !== {1'b1, 3'd1, 1'b0, 1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL hold cycle%0d: busy=%b grant=%0d wd_err=%b push=%b ready=%b, required 1 1 0 0 0010",
                     s, busy, grant_id, wd_err, fifo_push, req_ready);
         end
         tick();
      end
`endif
      req_valid = '0;
      $display("test_stall done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_pointer();
      test_round_robin();
      test_fifo_full();
      test_reset_mid_burst();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the 64-bit push side of one asymmetric_fifo instance among N_REQ producers.
- Each producer streams 64-bit words over a valid/ready handshake.
- A granted producer keeps the FIFO for a burst that ends at its last flag or after MAX_BURST words. The grant then rotates.
- Sits between producer engines and the FIFO. The 8-bit pop side is untouched.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 64, word width; matches FIFO push width
- MAX_BURST, 8, maximum words per grant (1..255)
- WD_CYCLES, 16, watchdog stall limit in cycles; used only when ARB_WATCHDOG_EN is defined

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester word valid
- req_last  in  N_REQ  per-requester last word of burst; qualified by valid
- req_data  in  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- fifo_push  out  1  push strobe to FIFO
- fifo_d  out  DATA_W  data to FIFO
- fifo_full  in  1  FIFO full flag
- grant_id  out  3  index of current or last granted requester
- busy  out  1  high while in BURST
- wd_err  out  1  watchdog release pulse (tied 0 without macro)

Behaviour:
- Reset (rst_n low, async): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, busy=0, wd_err=0. All outputs derived from state are therefore 0: req_ready=0, fifo_push=0. fifo_d=0.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register it into grant_id, clear beat_cnt, go to BURST next cycle.
  - Arbitration latency: 1 cycle. No transfer occurs in IDLE.
- BURST:
  - Datapath:
    - req_ready[grant_id] = ~fifo_full; all other ready bits are 0.
    - fifo_push = req_valid[grant_id] & ~fifo_full. This path is combinational; no extra latency.
    - fifo_d = req_data slice of grant_id, a combinational mux.
  - On each transfer, beat_cnt increments (8-bit, no wrap: the burst terminates first).
  - Burst ends on the transfer with req_last=1, or on the transfer where beat_cnt reaches MAX_BURST-1. Whichever occurs first wins.
  - On burst end: rr_ptr = grant_id+1 modulo N_REQ; next state = IDLE. There is one dead cycle between bursts.
- fifo_full high: no push, no ready, beat_cnt holds, grant held. Never push while fifo_full=1.
- Granted requester drops valid: grant held indefinitely without the macro.
- Only the granted requester can see ready. A requester raising valid mid-burst waits.
- Simultaneous last and MAX_BURST on the same transfer: a single burst end; rr_ptr advances once.
- N_REQ=1: the arbiter degenerates to IDLE/BURST toggling; rr_ptr stays 0.
- rst_n asserted mid-burst: immediate return to IDLE with all outputs 0. The partial burst is abandoned; words already pushed remain in the FIFO.
- grant_id holds its value in IDLE until the next arbitration.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined:
  - A 16-bit stall counter counts BURST cycles with req_valid[grant_id]=0 and fifo_full=0. It clears on any transfer.
  - When the counter reaches WD_CYCLES, the arbiter forces burst end: rr_ptr advances, state goes to IDLE, and wd_err pulses high for exactly 1 cycle.
  - Cycles stalled only by fifo_full never count.
- Not defined: no counter; wd_err tied 0; grant held until last or MAX_BURST.

Test Plan:
- Reset release, all valids 0: busy=0, fifo_push=0, req_ready=0, grant_id=0 for 10 cycles.
- Req 2 only, 3 words 0xA1..0xA3, last on third, fifo_full=0:
  - grant_id=2 one cycle after valid;
  - 3 consecutive pushes 0xA1,0xA2,0xA3;
  - busy falls the next cycle; rr_ptr=3.
- All 4 requesters continuously valid, never last, MAX_BURST=8:
  - grant order 0,1,2,3,0;
  - exactly 8 pushes per grant;
  - 1 idle cycle between grants.
- fifo_full asserted for 5 cycles mid-burst after word 2 of req 1: no push and req_ready=0 during the stall; the burst resumes with word 3; total words still 8.
- Req 0 valid with last=1 on its first word, req 3 also valid, rr_ptr=3: req 3 granted first, then req 0 with a 1-word burst.
- ARB_WATCHDOG_EN, WD_CYCLES=16: req 1 granted, pushes 2 words, then valid=0. wd_err pulses once 16 cycles after the last transfer; state returns to IDLE; req 2 (valid) is granted next.
